// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 7-segment scan reader.
// Glyphs are active-low with bit order g..a (bit0 = a).
package seg7_pkg;
  localparam int SEG_W  = 7;
  localparam int DIGITS = 4;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t GLYPH_0 = 7'h40;
  localparam seg_t GLYPH_1 = 7'h79;
  localparam seg_t GLYPH_2 = 7'h24;
  localparam seg_t GLYPH_3 = 7'h30;
  localparam seg_t GLYPH_4 = 7'h19;
  localparam seg_t GLYPH_5 = 7'h12;
  localparam seg_t GLYPH_6 = 7'h02;
  localparam seg_t GLYPH_7 = 7'h78;
  localparam seg_t GLYPH_8 = 7'h00;
  localparam seg_t GLYPH_9 = 7'h10;
  localparam seg_t GLYPH_A = 7'h08;
  localparam seg_t GLYPH_B = 7'h03;
  localparam seg_t GLYPH_C = 7'h46;
  localparam seg_t GLYPH_D = 7'h21;
  localparam seg_t GLYPH_E = 7'h06;
  localparam seg_t GLYPH_F = 7'h0E;
endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps an active-low segment pattern back to its hex nibble.
// Patterns outside the 16 legal glyphs report illegal and read as 0.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] nibble,
  output logic       illegal
);
  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b0;
    case (seg)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed active-low 4-digit 7-segment bus back into a 16-bit word
// with valid/ready handoff. Define SEG7_READER_DP_EN to also read decimal points.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  seg_t                seg_n,
  input  logic [DIGITS-1:0]   dig_n,
`ifdef SEG7_READER_DP_EN
  input  logic                dp_n,
  output logic [DIGITS-1:0]   dp,
`endif
  output logic [DIGITS*4-1:0] value,
  output logic [DIGITS-1:0]   err,
  output logic                value_valid,
  input  logic                value_ready,
  output logic                overrun
);
`ifdef SEG7_READER_DP_EN
  localparam int SW = SEG_W + 1;
`else
  localparam int SW = SEG_W;
`endif
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]       samp_in, samp_s1, samp_s2, samp_prev;
  logic [DIGITS-1:0]   dig_s1, dig_s2, dig_prev, dig_act;
  logic [7:0]          stab_cnt;
  logic                dig_onehot, stable, capture, frame_done, transfer;
  logic [3:0]          nibble;
  logic                illegal;
  logic [DIGITS-1:0]   captured;
  logic [DIGITS*4-1:0] slot_val;
  logic [DIGITS-1:0]   slot_err;

`ifdef SEG7_READER_DP_EN
  logic [DIGITS-1:0]   slot_dp;
  assign samp_in = {dp_n, seg_n};
`else
  assign samp_in = seg_n;
`endif

  assign dig_act    = ~dig_s2;
  assign dig_onehot = (dig_act != '0) && ((dig_act & (dig_act - 4'd1)) == '0);
  assign stable     = dig_onehot && (samp_s2 == samp_prev) && (dig_s2 == dig_prev);
  // Fires only on the step into CNT_MAX, so a held digit is taken once.
  assign capture    = stable && (stab_cnt == CNT_CAP);
  assign frame_done = (captured == '1);
  assign transfer   = value_valid && value_ready;

  seg7_glyph_decode u_decode (
    .seg     (samp_s2[SEG_W-1:0]),
    .nibble  (nibble),
    .illegal (illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_s1   <= '1;
      samp_s2   <= '1;
      samp_prev <= '1;
      dig_s1    <= '1;
      dig_s2    <= '1;
      dig_prev  <= '1;
      stab_cnt  <= '0;
    end else begin
      samp_s1   <= samp_in;
      samp_s2   <= samp_s1;
      samp_prev <= samp_s2;
      dig_s1    <= dig_n;
      dig_s2    <= dig_s1;
      dig_prev  <= dig_s2;
      if (!stable)                 stab_cnt <= '0;
      else if (stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      captured <= '0;
      slot_val <= '0;
      slot_err <= '0;
`ifdef SEG7_READER_DP_EN
      slot_dp  <= '0;
`endif
    end else begin
      captured <= (frame_done ? '0 : captured) | (capture ? dig_act : '0);
      for (int k = 0; k < DIGITS; k++) begin
        if (capture && dig_act[k]) begin
          slot_val[k*4 +: 4] <= nibble;
          slot_err[k]        <= illegal;
`ifdef SEG7_READER_DP_EN
          slot_dp[k]         <= ~samp_s2[SEG_W];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value       <= '0;
      err         <= '0;
      value_valid <= 1'b0;
      overrun     <= 1'b0;
`ifdef SEG7_READER_DP_EN
      dp          <= '0;
`endif
    end else begin
      if (frame_done && (!value_valid || value_ready)) begin
        value       <= slot_val;
        err         <= slot_err;
        value_valid <= 1'b1;
`ifdef SEG7_READER_DP_EN
        dp          <= slot_dp;
`endif
      end else if (transfer) begin
        value_valid <= 1'b0;
      end
      // A frame landing while the old word is still held is lost.
      if (transfer)                       overrun <= 1'b0;
      else if (frame_done && value_valid) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: table-driven scans, corner-case
// sequences, and a randomized dwell-level reference model.
module tb_seg7_scan_reader;
  import seg7_pkg::*;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  seg_t        seg_n;
  logic [3:0]  dig_n;
  logic [15:0] value;
  logic [3:0]  err;
  logic        value_valid;
  logic        value_ready;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  e;
  } word_t;

  typedef struct packed {
    logic [3:0][6:0] p;
    logic [15:0]     v;
    logic [3:0]      e;
  } vec_t;

  word_t got_q[$];
  word_t exp_q[$];
  seg_t  glyphs[16];
  vec_t  vt[5];

  always #5 clk = ~clk;

  seg7_scan_reader #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .value       (value),
    .err         (err),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .overrun     (overrun)
  );

  always @(negedge clk)
    if (!rst && value_valid && value_ready) got_q.push_back({value, err});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input seg_t a0, input seg_t a1, input seg_t a2, input seg_t a3,
                              input logic [15:0] v, input logic [3:0] e);
    vec_t r;
    r.p[0] = a0; r.p[1] = a1; r.p[2] = a2; r.p[3] = a3;
    r.v = v; r.e = e;
    return r;
  endfunction

  // Called at a negedge; holds the pattern for n cycles and returns at a negedge.
  task automatic drive(input seg_t s, input logic [3:0] d, input int n);
    seg_n = s;
    dig_n = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(7'h7F, 4'hF, n);
  endtask

  task automatic scan(input logic [3:0][6:0] p, input int dwell);
    for (int k = 0; k < 4; k++) drive(p[k], ~(4'b0001 << k), dwell);
    idle(8);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]  m_cap;
    logic [15:0] m_val;
    logic [3:0]  m_err;
    seg_t        prev_s;
    logic [3:0]  prev_d;
    int          bad;
    int          n;

    glyphs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vt[0] = mk(7'h79, 7'h24, 7'h30, 7'h19, 16'h4321, 4'b0000);
    vt[1] = mk(7'h40, 7'h7F, 7'h12, 7'h0E, 16'hF500, 4'b0010);
    vt[2] = mk(7'h08, 7'h03, 7'h46, 7'h21, 16'hDCBA, 4'b0000);
    vt[3] = mk(7'h00, 7'h10, 7'h02, 7'h78, 16'h7698, 4'b0000);
    vt[4] = mk(7'h06, 7'h0E, 7'h2A, 7'h40, 16'h00FE, 4'b0100);

    rst = 1'b1;
    seg_n = 7'h7F;
    dig_n = 4'hF;
    value_ready = 1'b1;
    #1;
    check("reset_value", 32'(value), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_valid", 32'(value_valid), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(4);

    for (int i = 0; i < 5; i++) begin
      got_q.delete();
      scan(vt[i].p, 10);
      check($sformatf("vec%0d_count", i), 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_value", i), 32'(got_q[0].v), 32'(vt[i].v));
        check($sformatf("vec%0d_err", i), 32'(got_q[0].e), 32'(vt[i].e));
      end
    end

    // Digit 2 shown too briefly: frame must stay open until it is shown properly.
    got_q.delete();
    drive(7'h79, 4'b1110, 10);
    drive(7'h24, 4'b1101, 10);
    drive(7'h0E, 4'b1011, STABLE - 1);
    drive(7'h19, 4'b0111, 10);
    idle(12);
    check("short_dwell_no_frame", 32'(got_q.size()), 32'd0);
    drive(7'h0E, 4'b1011, 10);
    idle(8);
    check("short_dwell_completed", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("short_dwell_value", 32'(got_q[0].v), 32'h4F21);

    // Exact dwell threshold on a fresh frame.
    got_q.delete();
    drive(7'h40, 4'b1110, STABLE + 1);
    drive(7'h40, 4'b1101, STABLE + 1);
    drive(7'h40, 4'b1011, STABLE + 1);
    drive(7'h79, 4'b0111, STABLE + 1);
    idle(8);
    check("min_dwell_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("min_dwell_value", 32'(got_q[0].v), 32'h1000);

    // Two enables low: counter held at zero, nothing captured.
    got_q.delete();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive(7'h40, 4'b1100, 1);
      if (dut.stab_cnt !== 8'd0) bad++;
    end
    idle(8);
    check("multi_enable_cnt_nonzero_cycles", 32'(bad), 32'd0);
    check("multi_enable_captured", 32'(dut.captured), 32'd0);

    // Backpressure: second frame dropped, first word held, overrun sticky.
    value_ready = 1'b0;
    scan(vt[0].p, 10);
    check("bp_valid", 32'(value_valid), 32'd1);
    check("bp_first_value", 32'(value), 32'h4321);
    check("bp_no_overrun_yet", 32'(overrun), 32'd0);
    scan(vt[2].p, 10);
    check("bp_value_held", 32'(value), 32'h4321);
    check("bp_overrun", 32'(overrun), 32'd1);
    value_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_cleared", 32'(value_valid), 32'd0);
    check("bp_overrun_cleared", 32'(overrun), 32'd0);

    // Reset mid-frame, then scan in reverse order to expose stale captures.
    got_q.delete();
    drive(7'h12, 4'b1110, 10);
    drive(7'h02, 4'b1101, 10);
    drive(7'h78, 4'b1011, 10);
    #2 rst = 1'b1;
    #1;
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_valid", 32'(value_valid), 32'd0);
    check("midrst_captured", 32'(dut.captured), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    drive(7'h21, 4'b0111, 10);
    drive(7'h46, 4'b1011, 10);
    drive(7'h03, 4'b1101, 10);
    drive(7'h08, 4'b1110, 10);
    idle(8);
    check("postrst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("postrst_value", 32'(got_q[0].v), 32'hDCBA);

    // Randomized dwells against a model of whole dwell periods.
    pulse_reset();
    idle(4);
    got_q.delete();
    exp_q.delete();
    m_cap = '0;
    m_val = '0;
    m_err = '0;
    prev_s = 7'h7F;
    prev_d = 4'hF;
    for (int i = 0; i < 300; i++) begin
      seg_t       s;
      logic [3:0] d;
      int         dw;
      int         k;
      logic [3:0] nib;
      logic       ill;
      do begin
        if ($urandom_range(0, 99) < 85) d = ~(4'b0001 << $urandom_range(0, 3));
        else begin
          do d = 4'($urandom_range(0, 15));
          while (d == 4'b1110 || d == 4'b1101 || d == 4'b1011 || d == 4'b0111);
        end
        if ($urandom_range(0, 99) < 75) s = glyphs[$urandom_range(0, 15)];
        else s = 7'($urandom);
      end while (s == prev_s && d == prev_d);
      dw = $urandom_range(2, 9);
      drive(s, d, dw);
      prev_s = s;
      prev_d = d;
      k = -1;
      for (int j = 0; j < 4; j++) if (d == ~(4'b0001 << j)) k = j;
      if (k >= 0 && dw >= STABLE + 1) begin
        nib = 4'h0;
        ill = 1'b1;
        for (int g = 0; g < 16; g++)
          if (glyphs[g] == s) begin nib = 4'(g); ill = 1'b0; end
        m_val[k*4 +: 4] = nib;
        m_err[k] = ill;
        m_cap[k] = 1'b1;
        if (m_cap == 4'hF) begin
          exp_q.push_back({m_val, m_err});
          m_cap = '0;
        end
      end
    end
    idle(10);
    check("rand_word_count", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("rand_value_%0d", i), 32'(got_q[i].v), 32'(exp_q[i].v));
      check($sformatf("rand_err_%0d", i), 32'(got_q[i].e), 32'(exp_q[i].e));
    end
    check("rand_no_overrun", 32'(overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Recovers hexadecimal digits from a multiplexed, active-low 4-digit 7-segment display bus. It is the inverse of the team's 4-bit-to-segment decoder: it watches the segment lines and digit enables, decodes each stable pattern back to a nibble, and hands the assembled 16-bit word to downstream logic over a valid/ready handshake. It is used as a display loop-back checker and as a reader for external panels.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a digit is captured (legal range 1..255).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- seg_n  in  7  segment lines, active-low; bit0 = a … bit6 = g; asynchronous to clk.
- dig_n  in  4  digit enables, active-low; bit0 = rightmost digit, bit3 = leftmost; asynchronous.
- value  out  16  decoded word; nibble k = digit k.
- err  out  4  per-digit flag: pattern was not one of the 16 legal glyphs; that nibble reads 0.
- value_valid  out  1  word available.
- value_ready  in  1  consumer accepts the word.
- overrun  out  1  sticky: a completed frame was dropped because the previous word was still pending.

## Operation
- Input path: seg_n and dig_n each pass through 2-FF synchronizers. All logic downstream of the synchronizers uses the synchronized copies.
- Legal glyphs (active-low, hex g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Any other pattern is illegal.
- Stability counter: 8-bit.
  - Clears whenever {seg, dig} differs from the previous synchronized sample.
  - Also clears whenever dig is not one-hot-low (zero or multiple enables low).
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture: on the cycle the counter reaches STABLE_CYCLES (and only that cycle), the digit selected by dig is written:
  - Decoded nibble to its slot, illegal bit to its err slot, captured[k] set.
  - A digit held indefinitely is captured only once per stable period.
- Frame completion: when captured == 4'b1111, the frame completes.
  - If no word is pending: slots copy to the value/err output registers, value_valid sets, captured clears.
  - If value_valid=1 and value_ready=0: the frame is dropped, overrun sets, captured clears.
- Handshake:
  - value_valid stays high and value/err stay constant until the cycle value_ready=1; that cycle is the transfer and valid clears next cycle.
  - A frame completing in the same cycle as a transfer is accepted (valid stays 1 with the new word) and does not set overrun.
  - overrun clears on the next transfer.
- Recapture: a digit captured twice before the frame completes overwrites its slot (latest wins).
- Reset (asynchronous, any time, including mid-frame or mid-handshake):
  - Outputs: value=0, err=0, value_valid=0, overrun=0.
  - Internal: captured=0, counter=0, synchronizers=all-ones (blank, no digit).

## Timing
- Latency from a stable input change to capture: 2 (sync) + STABLE_CYCLES cycles.
- value_valid rises 1 cycle after the capture that completes the frame.
- Minimum digit dwell to be read: STABLE_CYCLES + 1 clk periods.
- Throughput: at most one word per completed frame; value_ready may be held high permanently.

## Configuration
- SEG7_READER_DP_EN: adds input dp_n (1 bit, active-low decimal point) and output dp (4 bits, active-high).
  - dp_n is synchronized and stability-checked together with seg_n.
  - It is captured per digit and published with value under the same handshake.
  - Without the macro: neither port exists and stability uses only seg_n/dig_n.

## Structure
- Package seg7_pkg:
  - SEG_W=7, DIGITS=4.
  - The 16 glyph constants GLYPH_0..GLYPH_F.
  - Typedef seg_t (logic [6:0]).
- Sub-module seg7_glyph_decode: combinational seg_t → {nibble, illegal}, one instance per capture path.

## Test plan
- Scan digits 0..3 with glyphs 1,2,3,4 (79,24,30,19), 10-cycle dwell, value_ready=1 → value=16'h4321, err=0, one value_valid pulse per scan.
- Hold glyph 0E on digit 2 for 3 cycles then change, STABLE_CYCLES=4 → no capture; frame does not complete.
- Pattern 7F (blank) on digit 1, others legal → err=4'b0010, nibble1=0.
- value_ready=0 for two full frames → first word held unchanged, overrun=1; assert ready → transfer, overrun=0 next cycle.
- Two enables low (dig_n=4'b1100) for 20 cycles → no capture, counter stays 0.
- rst pulsed after 3 digits captured → all outputs 0; the subsequent full scan yields a correct word with no stale digits.
